// File: rtl/ifetch_pkg.sv
// Shared constants for the mipslite fetch front end: reset PC, opcode field bounds,
// instruction width and the RUN/DRAIN state encodings.
package ifetch_pkg;

  localparam int unsigned ILEN         = 32;
  localparam int unsigned OP_MSB       = 31;
  localparam int unsigned OP_LSB       = 26;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  typedef logic [ILEN-1:0] instr_t;

  function automatic logic [5:0] op_field(input instr_t instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order synchronous FIFO with flush; head is read combinationally (zero added latency).
// No internal backpressure: push on full is accepted only alongside a pop, flush drops pushes.
module fetch_queue #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [W-1:0]             push_dat_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_dat_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, do_push, do_pop;

  assign empty_o    = (cnt_q == '0);
  assign full       = (cnt_q == CW'(DEPTH));
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && !flush_i && (!full || do_pop);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = cnt_q;
  assign cnt_d      = cnt_q + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch front end: credit-limited sequential requests, in-order prefetch queue, redirect with drain.
// Accept N -> rsp N+1 -> dec_valid N+2; optional perf counters under IFETCH_PERF_EN.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int unsigned    DEPTH    = 2,
  parameter int unsigned    AW       = 32,
  parameter logic [AW-1:0]  RESET_PC = AW'(RESET_PC_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_rsp_valid,
  input  logic [31:0]   imem_rsp_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  input  logic          dec_ready,
  output logic          dec_valid,
  output logic [31:0]   dec_instr,
  output logic [AW-1:0] dec_pc,
  output logic [5:0]    dec_op,
  output logic          stall
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]   perf_stall_cnt,
  output logic [15:0]   perf_flush_cnt
`endif
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam int unsigned QW      = ILEN + AW;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] out_q, out_d, discard_q, discard_d;
  logic [CW-1:0] occ, tag_cnt;
  logic [AW-1:0] tag_pc, redir_pc;
  logic [QW-1:0] q_head;
  logic          q_empty, tag_empty, req_acc, rsp_keep, q_pop;
  logic          unused;

  assign redir_pc       = {redirect_pc[AW-1:2], 2'b00};
  assign imem_req_valid = !rst && (state_q == ST_RUN) && (({1'b0, occ} + {1'b0, out_q}) < CREDITS);
  assign imem_req_addr  = fetch_pc_q;
  assign req_acc        = imem_req_valid && imem_req_ready;
  // A word arriving with a redirect belongs to the old path and is dropped.
  assign rsp_keep       = imem_rsp_valid && (discard_q == '0) && !redirect_valid;

  assign dec_valid            = !q_empty;
  assign q_pop                = dec_valid && dec_ready;
  assign {dec_instr, dec_pc}  = dec_valid ? q_head : '0;
  assign dec_op               = op_field(dec_instr);
  assign stall                = !dec_valid;

  assign unused = ^{tag_empty, tag_cnt, redirect_pc[1:0]};

  // Tags are popped for every response, dropped or kept, so they never need flushing.
  fetch_queue #(.W(AW), .DEPTH(DEPTH)) u_tags (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (1'b0),
    .push_i     (req_acc),
    .push_dat_i (fetch_pc_q),
    .pop_i      (imem_rsp_valid),
    .head_dat_o (tag_pc),
    .empty_o    (tag_empty),
    .count_o    (tag_cnt)
  );

  fetch_queue #(.W(QW), .DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redirect_valid),
    .push_i     (rsp_keep),
    .push_dat_i ({imem_rsp_data, tag_pc}),
    .pop_i      (q_pop),
    .head_dat_o (q_head),
    .empty_o    (q_empty),
    .count_o    (occ)
  );

  always_comb begin
    out_d      = out_q + CW'(req_acc) - CW'(imem_rsp_valid);
    discard_d  = discard_q;
    fetch_pc_d = fetch_pc_q;
    state_d    = state_q;
    if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
    if (req_acc) fetch_pc_d = fetch_pc_q + AW'(4);
    if ((state_q == ST_DRAIN) && (discard_d == '0)) state_d = ST_RUN;
    if (redirect_valid) begin
      fetch_pc_d = redir_pc;
      discard_d  = out_d;
      state_d    = (out_d != '0) ? ST_DRAIN : ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      discard_q  <= discard_d;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redirect_valid) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a latency-programmable in-order memory model.
// Define IFETCH_PERF_EN to also exercise the perf counters.
module tb_ifetch_unit;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready, dec_valid;
  logic [31:0] dec_instr, dec_pc;
  logic [5:0]  dec_op;
  logic        stall;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ifetch_unit #(.DEPTH(DEPTH), .AW(32), .RESET_PC(32'h0000_3000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_ready      (dec_ready),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_op         (dec_op),
    .stall          (stall)
`ifdef IFETCH_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'h3C01_0001 + ((a - 32'h0000_3000) >> 2);
  endfunction

  // Memory model: 0 = always ready, 1 = random ready, 2 = never ready.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] req_log[$];
  int rdy_mode = 0;
  int lat_min  = 1;
  int lat_max  = 1;
  int cyc      = 0;
  int last_due = 0;
  int n_acc    = 0;
  int n_rsp    = 0;
  int max_load = 0;

  initial begin
    pend_t p, dropped;
    int    lat, load;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      case (rdy_mode)
        0:       imem_req_ready = 1'b1;
        1:       imem_req_ready = 1'($urandom_range(0, 1));
        default: imem_req_ready = 1'b0;
      endcase
      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_of(pend_q[0].addr);
        dropped = pend_q.pop_front();
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
      @(negedge clk);
      if (rst) begin
        pend_q.delete();
        last_due = 0;
        n_acc    = 0;
        n_rsp    = 0;
      end else begin
        load = int'(dut.occ) + n_acc - n_rsp;
        if (load > max_load) max_load = load;
        if (imem_rsp_valid) n_rsp++;
        if (imem_req_valid && imem_req_ready) begin
          lat    = int'($urandom_range(lat_max, lat_min));
          p.addr = imem_req_addr;
          p.due  = cyc + lat;
          if (p.due <= last_due) p.due = last_due + 1;
          last_due = p.due;
          pend_q.push_back(p);
          req_log.push_back(imem_req_addr);
          n_acc++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of the first cycle with rst low ("cycle 1").
  task automatic do_reset();
    step();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    dec_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    req_log.delete();
    max_load = 0;
  endtask

  task automatic test_reset();
    rdy_mode = 0; lat_min = 1; lat_max = 1;
    step();
    rst = 1'b1;
    dec_ready = 1'b1;
    repeat (2) step();
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %0b exp 0", imem_req_valid); end
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid got %0b exp 0", dec_valid); end
    checks++; if (dec_instr !== 32'h0) begin errors++; $display("FAIL reset_dec_instr got %h exp 0", dec_instr); end
    checks++; if (dec_pc !== 32'h0) begin errors++; $display("FAIL reset_dec_pc got %h exp 0", dec_pc); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall got %0b exp 1", stall); end
    checks++; if (imem_req_addr !== 32'h3000) begin errors++; $display("FAIL reset_fetch_pc got %h exp 3000", imem_req_addr); end
  endtask

  task automatic test_fetch();
    logic [31:0] pcs[$];
    logic [31:0] ins[$];
    logic [31:0] e;
    rdy_mode = 0; lat_min = 1; lat_max = 1;
    do_reset();
    dec_ready = 1'b1;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h3000) begin errors++; $display("FAIL fetch_c1_req got %0b/%h exp 1/3000", imem_req_valid, imem_req_addr); end
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL fetch_c1_dec_valid got %0b exp 0", dec_valid); end
    step(); @(negedge clk);
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL fetch_c2_dec_valid got %0b exp 0", dec_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h3004) begin errors++; $display("FAIL fetch_c2_req got %0b/%h exp 1/3004", imem_req_valid, imem_req_addr); end
    step(); @(negedge clk);
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h3000) begin errors++; $display("FAIL fetch_c3_head got %0b/%h exp 1/3000", dec_valid, dec_pc); end
    checks++; if (dec_instr !== 32'h3C01_0001) begin errors++; $display("FAIL fetch_c3_instr got %h exp 3c010001", dec_instr); end
    checks++; if (dec_op !== 6'h0F) begin errors++; $display("FAIL fetch_c3_op got %h exp 0f", dec_op); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fetch_c3_stall got %0b exp 0", stall); end
    if (dec_valid && dec_ready) begin pcs.push_back(dec_pc); ins.push_back(dec_instr); end
    repeat (12) begin
      step(); @(negedge clk);
      if (dec_valid && dec_ready) begin pcs.push_back(dec_pc); ins.push_back(dec_instr); end
    end
    for (int i = 0; i < 3; i++) begin
      e = 32'h3000 + 32'(4 * i);
      checks++;
      if (pcs.size() <= i || pcs[i] !== e || ins[i] !== word_of(e)) begin
        errors++; $display("FAIL fetch_seq_%0d got %0d pops exp pc %h", i, pcs.size(), e);
      end
    end
  endtask

  task automatic test_backpressure();
    rdy_mode = 0; lat_min = 1; lat_max = 1;
    do_reset();
    repeat (10) step();
    @(negedge clk);
    checks++; if (req_log.size() != 2) begin errors++; $display("FAIL bp_req_count got %0d exp 2", req_log.size()); end
    checks++; if (req_log.size() < 2 || req_log[0] !== 32'h3000 || req_log[1] !== 32'h3004) begin errors++; $display("FAIL bp_req_addrs got %0d entries exp 3000,3004", req_log.size()); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid got %0b exp 0", imem_req_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bp_stall got %0b exp 0", stall); end
    checks++; if (dec_pc !== 32'h3000 || dec_instr !== word_of(32'h3000)) begin errors++; $display("FAIL bp_head got %h/%h exp 3000", dec_pc, dec_instr); end
    step(); dec_ready = 1'b1; @(negedge clk);
    checks++; if (dec_pc !== 32'h3000) begin errors++; $display("FAIL bp_pop_head got %h exp 3000", dec_pc); end
    step(); dec_ready = 1'b0; @(negedge clk);
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h3004) begin errors++; $display("FAIL bp_second got %0b/%h exp 1/3004", dec_valid, dec_pc); end
  endtask

  task automatic test_redirect_drain();
    int c;
    rdy_mode = 0; lat_min = 3; lat_max = 3;
    do_reset();
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_4001;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL drain_c3_req got %0b exp 0", imem_req_valid); end
    step(); redirect_valid = 1'b0; redirect_pc = '0; @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0) begin errors++; $display("FAIL drain_c4 got req %0b dec %0b exp 0/0", imem_req_valid, dec_valid); end
    step(); @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0) begin errors++; $display("FAIL drain_c5 got req %0b dec %0b exp 0/0", imem_req_valid, dec_valid); end
    step(); @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4000) begin errors++; $display("FAIL drain_c6_req got %0b/%h exp 1/4000", imem_req_valid, imem_req_addr); end
    c = 6;
    while (!dec_valid && c < 30) begin step(); c++; @(negedge clk); end
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h4000) begin errors++; $display("FAIL drain_first_pc got %0b/%h exp 1/4000", dec_valid, dec_pc); end
    checks++; if (c != 10) begin errors++; $display("FAIL drain_first_cycle got %0d exp 10", c); end
  endtask

  task automatic test_redirect_pop_rsp();
    logic [31:0] pcs[$];
    rdy_mode = 0; lat_min = 1; lat_max = 1;
    do_reset();
    dec_ready = 1'b1;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_5000;
    @(negedge clk);
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h3000) begin errors++; $display("FAIL rpr_pop got %0b/%h exp 1/3000", dec_valid, dec_pc); end
    step(); redirect_valid = 1'b0; redirect_pc = '0; @(negedge clk);
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rpr_flushed got %0b exp 0", dec_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h5000) begin errors++; $display("FAIL rpr_req got %0b/%h exp 1/5000", imem_req_valid, imem_req_addr); end
    repeat (10) begin
      step(); @(negedge clk);
      if (dec_valid && dec_ready) pcs.push_back(dec_pc);
    end
    checks++; if (pcs.size() < 2 || pcs[0] !== 32'h5000 || pcs[1] !== 32'h5004) begin errors++; $display("FAIL rpr_new_path got %0d pops first %h exp 5000,5004", pcs.size(), (pcs.size() > 0) ? pcs[0] : 32'h0); end
  endtask

  task automatic test_redirect_accept();
    rdy_mode = 0; lat_min = 1; lat_max = 1;
    do_reset();
    dec_ready = 1'b1;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_6000;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h3004) begin errors++; $display("FAIL racc_c2_req got %0b/%h exp 1/3004", imem_req_valid, imem_req_addr); end
    step(); redirect_valid = 1'b0; redirect_pc = '0; @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0) begin errors++; $display("FAIL racc_c3 got req %0b dec %0b exp 0/0", imem_req_valid, dec_valid); end
    step(); @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h6000) begin errors++; $display("FAIL racc_c4_req got %0b/%h exp 1/6000", imem_req_valid, imem_req_addr); end
    step(); step(); @(negedge clk);
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h6000) begin errors++; $display("FAIL racc_c6_head got %0b/%h exp 1/6000", dec_valid, dec_pc); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, tgt, w;
    int npop;
    rdy_mode = 1; lat_min = 1; lat_max = 4;
    do_reset();
    exp_pc = 32'h3000;
    tgt    = '0;
    npop   = 0;
    for (int i = 0; i < 800; i++) begin
      dec_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        tgt = 32'h0001_0000 + ($urandom_range(0, 255) << 2);
        redirect_valid = 1'b1;
        redirect_pc = tgt;
      end else begin
        redirect_valid = 1'b0;
      end
      @(negedge clk);
      if (dec_valid && dec_ready) begin
        w = word_of(exp_pc);
        checks++; if (dec_pc !== exp_pc) begin errors++; $display("FAIL rnd_pc got %h exp %h", dec_pc, exp_pc); end
        checks++; if (dec_instr !== w || dec_op !== w[31:26]) begin errors++; $display("FAIL rnd_instr got %h/%h exp %h", dec_instr, dec_op, w); end
        exp_pc = exp_pc + 32'd4;
        npop++;
      end
      if (redirect_valid) exp_pc = tgt;
      step();
    end
    redirect_valid = 1'b0;
    dec_ready = 1'b0;
    checks++; if (npop < 40) begin errors++; $display("FAIL rnd_progress got %0d pops exp >=40", npop); end
    checks++; if (max_load > DEPTH) begin errors++; $display("FAIL rnd_credit got %0d exp <=%0d", max_load, DEPTH); end
  endtask

`ifdef IFETCH_PERF_EN
  task automatic test_perf();
    rdy_mode = 2;
    do_reset();
    @(negedge clk);
    checks++; if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 16'd0) begin errors++; $display("FAIL perf_start got %0d/%0d exp 0/0", perf_stall_cnt, perf_flush_cnt); end
    repeat (10) step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_7000;
    @(negedge clk);
    checks++; if (perf_stall_cnt !== 32'd10) begin errors++; $display("FAIL perf_stall10 got %0d exp 10", perf_stall_cnt); end
    checks++; if (perf_flush_cnt !== 16'd0) begin errors++; $display("FAIL perf_flush0 got %0d exp 0", perf_flush_cnt); end
    step(); redirect_valid = 1'b0; @(negedge clk);
    checks++; if (perf_flush_cnt !== 16'd1) begin errors++; $display("FAIL perf_flush1 got %0d exp 1", perf_flush_cnt); end
    checks++; if (perf_stall_cnt !== 32'd11) begin errors++; $display("FAIL perf_stall11 got %0d exp 11", perf_stall_cnt); end
    step(); rst = 1'b1;
    step(); rst = 1'b0; @(negedge clk);
    checks++; if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 16'd0) begin errors++; $display("FAIL perf_rst got %0d/%0d exp 0/0", perf_stall_cnt, perf_flush_cnt); end
    rdy_mode = 0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    dec_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    test_reset();
    test_fetch();
    test_backpressure();
    test_redirect_drain();
    test_redirect_pop_rsp();
    test_redirect_accept();
    test_random();
`ifdef IFETCH_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
